// File: rtl/pattern_bank_sequencer_if.sv
// Config and stream signal bundle for pattern_bank_sequencer.
// master = configuration master / stream consumer side; slave = the sequencer.
interface pattern_bank_sequencer_if #(
  parameter int ADDR_W = 3
);
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [0:4][4:1]   cfg_wdata;
  logic              cfg_err;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] last_idx;
  logic              out_valid;
  logic              out_ready;
  logic [0:4][4:1]   out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              busy;
  logic              done;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, stop, loop_en, last_idx, out_ready,
    input  cfg_err, out_valid, out_data, out_idx, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, stop, loop_en, last_idx, out_ready,
    output cfg_err, out_valid, out_data, out_idx, busy, done
  );
endinterface

// File: rtl/pattern_bank_sequencer.sv
// Pattern bank loaded over a config port and played out on a valid/ready stream.
// Optional macro PATTERN_XZ_CHECK_EN adds the xz_err output flagging X/Z in accepted writes.
module pattern_bank_sequencer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  pattern_bank_sequencer_if.slave bus
`ifdef PATTERN_XZ_CHECK_EN
  ,
  output logic xz_err
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] out_idx;
  logic [ADDR_W-1:0] last;
  logic              cfg_err;
  logic [0:4][4:1]   bank [DEPTH];
  logic              write_ok;
  logic              handshake;

  // Writes are only accepted while no playback is in flight, keeping out_data stable.
  assign write_ok  = (state == IDLE) || (state == DONE);
  assign handshake = (state == RUN) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
      cfg_err <= 1'b0;
    end else begin
      if (bus.cfg_we && write_ok) begin
        bank[bus.cfg_addr] <= bus.cfg_wdata;
      end
      cfg_err <= bus.cfg_we && (state == RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      out_idx <= '0;
      last    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= RUN;
            out_idx <= '0;
            last    <= bus.last_idx;
          end
        end
        RUN: begin
          // stop wins over both the index advance and the transition to DONE.
          if (bus.stop) begin
            state <= IDLE;
          end else if (handshake) begin
            if (out_idx != last) begin
              out_idx <= out_idx + ADDR_W'(1);
            end else if (bus.loop_en) begin
              out_idx <= '0;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PATTERN_XZ_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xz_err <= 1'b0;
    end else begin
      xz_err <= bus.cfg_we && write_ok && ((^bus.cfg_wdata) === 1'bx);
    end
  end
`endif

  assign bus.out_valid = (state == RUN);
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.cfg_err   = cfg_err;
  assign bus.out_idx   = out_idx;
  assign bus.out_data  = bank[out_idx];

endmodule

// File: tb/tb_pattern_bank_sequencer.sv
// Directed self-checking bench for pattern_bank_sequencer (DEPTH=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pattern_bank_sequencer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  pattern_bank_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef PATTERN_XZ_CHECK_EN
  logic xz_err;
`endif

  pattern_bank_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef PATTERN_XZ_CHECK_EN
    ,
    .xz_err (xz_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic sp, input logic lp,
                               input logic [ADDR_W-1:0] li, input logic rdy);
    bus.start     = s;
    bus.stop      = sp;
    bus.loop_en   = lp;
    bus.last_idx  = li;
    bus.out_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic writeWord(input logic [ADDR_W-1:0] addr, input logic [19:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    step();
    bus.cfg_we    = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
    $display("[TB] reset checks");
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    checkOutput("rst_idx", 32'(bus.out_idx), 32'd0);
    checkOutput("rst_data", 32'(bus.out_data), 32'd0);
`ifdef PATTERN_XZ_CHECK_EN
    checkOutput("rst_xz_err", 32'(xz_err), 32'd0);
`endif

    // Load entries 0..3 with one-hot words.
    writeWord(3'd0, 20'h00001);
    writeWord(3'd1, 20'h00002);
    writeWord(3'd2, 20'h00004);
    writeWord(3'd3, 20'h00008);

    $display("[TB] single pass");
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd3, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    checkOutput("sp_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("sp_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("sp_idx", 32'(bus.out_idx), 32'(i));
      checkOutput("sp_data", 32'(bus.out_data), 32'(1 << i));
      step();
    end
    checkOutput("sp_done", 32'(bus.done), 32'd1);
    checkOutput("sp_done_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("sp_done_busy", 32'(bus.busy), 32'd0);
    step();
    checkOutput("sp_done_pulse", 32'(bus.done), 32'd0);

    $display("[TB] looped playback");
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("loop_idx", 32'(bus.out_idx), 32'(i % 4));
      checkOutput("loop_done", 32'(bus.done), 32'd0);
      step();
    end
    // Now at idx 2: stall for two cycles.
    checkOutput("stall_pre_idx", 32'(bus.out_idx), 32'd2);
    bus.out_ready = 1'b0;
    step();
    checkOutput("stall1_idx", 32'(bus.out_idx), 32'd2);
    checkOutput("stall1_data", 32'(bus.out_data), 32'h00004);
    step();
    checkOutput("stall2_idx", 32'(bus.out_idx), 32'd2);
    checkOutput("stall2_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    step();
    checkOutput("stall_resume_idx", 32'(bus.out_idx), 32'd3);
    checkOutput("stall_resume_data", 32'(bus.out_data), 32'h00008);

    $display("[TB] write during run");
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'd2;
    bus.cfg_wdata = 20'hFFFFF;
    bus.start     = 1'b1;
    step();
    bus.cfg_we    = 1'b0;
    bus.start     = 1'b0;
    checkOutput("run_wr_cfg_err", 32'(bus.cfg_err), 32'd1);
    checkOutput("run_wr_wrap_idx", 32'(bus.out_idx), 32'd0);
    step();
    checkOutput("run_wr_cfg_err_pulse", 32'(bus.cfg_err), 32'd0);
    checkOutput("run_start_ignored_idx", 32'(bus.out_idx), 32'd1);
    step();
    checkOutput("run_wr_bank2_idx", 32'(bus.out_idx), 32'd2);
    checkOutput("run_wr_bank2_data", 32'(bus.out_data), 32'h00004);

    $display("[TB] stop with handshake");
    step();
    step();
    step();
    checkOutput("stop_pre_idx", 32'(bus.out_idx), 32'd1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    checkOutput("stop_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("stop_busy", 32'(bus.busy), 32'd0);
    checkOutput("stop_done", 32'(bus.done), 32'd0);
    step();
    checkOutput("stop_done_later", 32'(bus.done), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd3, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    checkOutput("restart_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("restart_idx", 32'(bus.out_idx), 32'd0);

    $display("[TB] reset mid-run");
    step();
    step();
    checkOutput("mid_rst_pre_idx", 32'(bus.out_idx), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_rst_idx", 32'(bus.out_idx), 32'd0);
    checkOutput("mid_rst_data", 32'(bus.out_data), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd3, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("cleared_idx", 32'(bus.out_idx), 32'(i));
      checkOutput("cleared_data", 32'(bus.out_data), 32'd0);
      step();
    end
    checkOutput("cleared_done", 32'(bus.done), 32'd1);
    step();

    $display("[TB] single-entry loop");
    writeWord(3'd0, 20'h12345);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("one_idx", 32'(bus.out_idx), 32'd0);
      checkOutput("one_data", 32'(bus.out_data), 32'h12345);
      checkOutput("one_valid", 32'(bus.out_valid), 32'd1);
      step();
    end
    bus.loop_en = 1'b0;
    step();
    checkOutput("one_done", 32'(bus.done), 32'd1);
    step();
    checkOutput("one_done_pulse", 32'(bus.done), 32'd0);
    checkOutput("one_idle_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pattern_bank_sequencer.md
Name: pattern_bank_sequencer

Overview:
- Sequencer for the packed 5x4 pattern datapath. A small bank of 20-bit pattern words (type [0:4][4:1]) is loaded through a config port, then played out in order on a valid/ready stream.
- Supports single-pass and looped playback, abort, and per-word index reporting.
- Sits between the test-pattern configuration master and the consumer of the packed pattern array.

Parameters:
- DEPTH, 8, number of pattern entries in the bank (power of two, minimum 2).
- ADDR_W, 3, entry address width; equals $clog2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- cfg_we  input  1  bank write strobe.
- cfg_addr  input  ADDR_W  bank write address.
- cfg_wdata  input  [0:4][4:1] (20)  pattern word to store.
- cfg_err  output  1  one-cycle pulse: write rejected because the block is busy.
- start  input  1  begin playback at entry 0.
- stop  input  1  abort playback.
- loop_en  input  1  wrap to entry 0 after the last entry instead of finishing.
- last_idx  input  ADDR_W  index of the final entry to play; sampled on start.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_data  output  [0:4][4:1] (20)  current pattern word, bank[out_idx].
- out_idx  output  ADDR_W  index of the current word.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when single-pass playback completes.

Behaviour:
- Reset: state IDLE.
  - out_valid=0, busy=0, done=0, cfg_err=0, out_idx=0, internal last register=0.
  - Bank contents are cleared to 0.
- Bank: DEPTH x 20-bit registers.
  - Write when cfg_we=1 and state is IDLE or DONE; data is visible the next cycle.
  - cfg_we in RUN: no write; cfg_err=1 on the next cycle.
- out_data: combinational read of bank[out_idx]. It is stable while out_valid=1, because writes are blocked in RUN.
- States:
  - IDLE: start=1 -> RUN; out_idx<=0, last<=last_idx. stop has no effect.
  - RUN: out_valid=1, busy=1. A handshake (out_valid & out_ready) advances:
    - out_idx!=last: out_idx<=out_idx+1.
    - out_idx==last and loop_en=1: out_idx<=0; stay in RUN.
    - out_idx==last and loop_en=0: -> DONE.
    - loop_en is sampled on every handshake, so it may change mid-run.
  - RUN with stop=1: -> IDLE next cycle with out_valid=0 and no done pulse.
    - If a handshake occurs in the same cycle, that beat counts as delivered.
    - stop takes priority over the advance and over entering DONE.
  - DONE: done=1 for exactly one cycle, out_valid=0, then -> IDLE. start in DONE is ignored.
- start while in RUN: ignored.
- Latency: start at cycle N -> out_valid=1 with out_idx=0 at cycle N+1.
- Throughput: with out_ready held high, one word per cycle, and back-to-back loop wrap has no bubble.
- last_idx=0: single-entry playback. With loop_en=1, entry 0 repeats every cycle.
- Backpressure: out_ready=0 holds out_idx and out_data unchanged indefinitely.
- Reset mid-RUN: next cycle IDLE with all outputs at reset values, bank cleared.
- Counter arithmetic: out_idx is modulo 2^ADDR_W. No state beyond `last` is reachable from out_idx.

Optional Feature:
- Macro: PATTERN_XZ_CHECK_EN.
- Defined (simulation-only checking for the 4-state pattern sources):
  - Adds output xz_err (1 bit, reset 0).
  - xz_err pulses for one cycle after any accepted cfg_wdata contains X or Z bits, detected via ^cfg_wdata === 1'bx.
  - The word is still stored unchanged.
- Undefined: port xz_err is absent and no check logic is elaborated.

Test Plan:
- Write entries 0..3 = 20'h00001, 20'h00002, 20'h00004, 20'h00008; last_idx=3, loop_en=0, start, out_ready=1 -> out_idx 0,1,2,3 on consecutive cycles with matching out_data; done pulses one cycle after the idx-3 beat; busy falls.
- Same bank, loop_en=1, out_ready=1 for 10 cycles -> out_idx sequence 0,1,2,3,0,1,2,3,0,1; done never asserts.
- During RUN, toggle out_ready 1,0,0,1 -> out_idx and out_data hold through the two stall cycles; advance only on ready cycles.
- cfg_we=1 with addr=2, data=20'hFFFFF during RUN -> cfg_err pulses next cycle; bank[2] still reads 20'h00004 on the next pass.
- stop asserted together with a handshake at out_idx=1 -> next cycle IDLE, out_valid=0, done=0; a new start restarts at out_idx=0.
- rst asserted mid-RUN at out_idx=2 -> next cycle: out_valid=0, busy=0, out_idx=0, all bank entries read 0.
